// File: rtl/sysarr_pkg.sv
// Shared sizes, FSM state encoding and lane helpers for the systolic-array operand feeder.
package sysarr_pkg;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int DRAIN = N;
    localparam int IW    = $clog2(N);
    localparam int CW    = $clog2(2 * N - 1 + DRAIN);

    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 2 + DRAIN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [W-1:0] lane_slice(input logic [N*W-1:0] vec, input int unsigned idx);
        return vec[idx*W +: W];
    endfunction

endpackage

// File: rtl/sysarr_skew_lane.sv
// One skewed edge lane: presents element (t - K) of its row/column vector, or zero outside the window.
module sysarr_skew_lane
    import sysarr_pkg::*;
#(
    parameter int K = 0
) (
    input  logic [CW-1:0]  t,
    input  logic [N*W-1:0] vec,
    output logic [W-1:0]   elem
);

    logic signed [CW:0] rel_s;

    // Select the element that lane K should carry at step t.
    always_comb begin
        rel_s = $signed({1'b0, t}) - $signed((CW+1)'(K));
        if ((rel_s >= $signed((CW+1)'(0))) && (rel_s < $signed((CW+1)'(N)))) begin
            elem = lane_slice(vec, 32'(rel_s[CW-1:0]));
        end else begin
            elem = {W{1'b0}};
        end
    end

endmodule

// File: rtl/sysarr_feeder.sv
// Holds A (rows) and B (columns) and streams them skewed into a 4x4 systolic array,
// clearing the accumulators first and waiting for the wavefront to drain before signalling done.
module sysarr_feeder
    import sysarr_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_valid,
    output logic           ld_ready,
    input  logic           ld_sel,
    input  logic [IW-1:0]  ld_idx,
    input  logic [N*W-1:0] ld_data,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           acc_clr,
    output logic [N*W-1:0] l_out,
    output logic [N*W-1:0] u_out
);

    state_e         state_r, state_nxt_s;
    logic [CW-1:0]  step_r, step_nxt_s;
    logic [N*W-1:0] a_r [N];
    logic [N*W-1:0] b_r [N];
    logic [N*W-1:0] l_lane_s, u_lane_s;
    logic [N*W-1:0] l_nxt_s, u_nxt_s, l_r, u_r;
    logic           busy_nxt_s, done_nxt_s, clr_nxt_s;
    logic           busy_r, done_r, clr_r;
    logic           ld_take_s;

    // Lanes look at the upcoming step so the registered outputs line up with the state they belong to.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        sysarr_skew_lane #(.K(gi)) u_row (.t(step_nxt_s), .vec(a_r[gi]), .elem(l_lane_s[gi*W +: W]));
        sysarr_skew_lane #(.K(gi)) u_col (.t(step_nxt_s), .vec(b_r[gi]), .elem(u_lane_s[gi*W +: W]));
    end

    assign ld_ready  = (state_r == ST_IDLE) & ~start;
    assign ld_take_s = ld_valid & ld_ready;

    // State and step counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            step_r  <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            step_r  <= step_nxt_s;
        end
    end

    // Next-state and step sequencing; one counter spans FEED and DRAIN.
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = {CW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_nxt_s = ST_FEED;
            ST_FEED: begin
                step_nxt_s = step_r + CW'(1);
                if (step_r == FEED_LAST) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FEED;
                end
            end
            ST_DRAIN: begin
                if (step_r == DRAIN_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                    step_nxt_s  = step_r + CW'(1);
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        busy_nxt_s = (state_nxt_s == ST_CLEAR) | (state_nxt_s == ST_FEED) | (state_nxt_s == ST_DRAIN);
        done_nxt_s = (state_nxt_s == ST_DONE);
        clr_nxt_s  = (state_nxt_s == ST_CLEAR);
        if (state_nxt_s == ST_FEED) begin
            l_nxt_s = l_lane_s;
            u_nxt_s = u_lane_s;
        end else begin
            l_nxt_s = {(N*W){1'b0}};
            u_nxt_s = {(N*W){1'b0}};
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            clr_r  <= 1'b0;
            l_r    <= {(N*W){1'b0}};
            u_r    <= {(N*W){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            clr_r  <= clr_nxt_s;
            l_r    <= l_nxt_s;
            u_r    <= u_nxt_s;
        end
    end

    // Operand storage; B is kept column-wise so both edges share the same lane logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                a_r[k] <= {(N*W){1'b0}};
                b_r[k] <= {(N*W){1'b0}};
            end
        end else if (ld_take_s) begin
            if (ld_sel == 1'b0) begin
                a_r[ld_idx] <= ld_data;
            end else begin
                b_r[ld_idx] <= ld_data;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign acc_clr = clr_r;
    assign l_out   = l_r;
    assign u_out   = u_r;

endmodule

// File: tb/tb_sysarr_feeder.sv
// Directed bench for sysarr_feeder with a behavioural 4x4 systolic array on its outputs.
module tb_sysarr_feeder;
    import sysarr_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           ld_valid, ld_ready, ld_sel, start, busy, done, acc_clr;
    logic [IW-1:0]  ld_idx;
    logic [N*W-1:0] ld_data, l_out, u_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sysarr_feeder dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
        .ld_idx(ld_idx), .ld_data(ld_data), .start(start), .busy(busy), .done(done),
        .acc_clr(acc_clr), .l_out(l_out), .u_out(u_out)
    );

    // Behavioural output-stationary systolic array; acc_clr acts as its reset.
    logic [W-1:0] pl [N][N];
    logic [W-1:0] pu [N][N];
    logic [W-1:0] acc [N][N];

    always @(posedge clk or negedge rst) begin : mdl
        logic [W-1:0] lin, uin;
        if (!rst || acc_clr) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pl[i][j] <= '0; pu[i][j] <= '0; acc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (j == 0) lin = l_out[i*W +: W]; else lin = pl[i][j-1];
                    if (i == 0) uin = u_out[j*W +: W]; else uin = pu[i-1][j];
                    acc[i][j] <= acc[i][j] + lin * uin;
                    pl[i][j]  <= lin;
                    pu[i][j]  <= uin;
                end
        end
    end

    typedef struct {
        int             cyc;
        logic [N*W-1:0] l;
        logic [N*W-1:0] u;
        logic [2:0]     ctl;   // {busy, done, acc_clr}
    } vec_t;

    vec_t tbl [12];

    function automatic logic [N*W-1:0] pk(input int l3, input int l2, input int l1, input int l0);
        return {W'(l3), W'(l2), W'(l1), W'(l0)};
    endfunction

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_array(input string name, input bit zero);
        logic [N*W-1:0] bad_cnt;
        bad_cnt = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (acc[i][j] !== (zero ? W'(0) : W'(4 * i + j + 1))) bad_cnt = bad_cnt + 1'b1;
        check(name, bad_cnt, '0);
    endtask

    task automatic load(input logic sel, input int idx, input logic [N*W-1:0] data);
        ld_valid = 1'b1; ld_sel = sel; ld_idx = IW'(idx); ld_data = data;
        #1;
        check("ld_ready_idle", {{(N*W-1){1'b0}}, ld_ready}, pk(0, 0, 0, 1));
        tick();
        ld_valid = 1'b0;
    endtask

    // One run against the table; optional stray start pulse, busy-time load, or load alongside start.
    task automatic run_table(input string tag, input int pulse_cyc, input int ld_cyc, input bit ld_with_start);
        start = 1'b1;
        if (ld_with_start) begin
            ld_valid = 1'b1; ld_sel = 1'b0; ld_idx = '0; ld_data = {N{32'h5555_5555}};
        end
        #1;
        check({tag, "_ready_at_start"}, {{(N*W-1){1'b0}}, ld_ready}, '0);
        for (int c = 1; c <= 14; c++) begin
            tick();
            start    = (c == pulse_cyc);
            ld_valid = (c == ld_cyc);
            ld_sel   = 1'b0; ld_idx = '0; ld_data = {N{32'h0000_0063}};
            #1;
            if (c == ld_cyc) check({tag, "_ready_busy"}, {{(N*W-1){1'b0}}, ld_ready}, '0);
            for (int k = 0; k < 12; k++) begin
                if (tbl[k].cyc == c) begin
                    check($sformatf("%s_l_c%0d", tag, c), l_out, tbl[k].l);
                    check($sformatf("%s_u_c%0d", tag, c), u_out, tbl[k].u);
                    check($sformatf("%s_ctl_c%0d", tag, c), {{(N*W-3){1'b0}}, busy, done, acc_clr},
                          {{(N*W-3){1'b0}}, tbl[k].ctl});
                end
            end
            if (c == 13) check_array({tag, "_array"}, 1'b0);
        end
        start = 1'b0; ld_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1,  '0,                 '0,             3'b101};
        tbl[1]  = '{2,  pk(0, 0, 0, 1),     pk(0, 0, 0, 1), 3'b100};
        tbl[2]  = '{3,  pk(0, 0, 5, 2),     '0,             3'b100};
        tbl[3]  = '{4,  pk(0, 9, 6, 3),     pk(0, 0, 1, 0), 3'b100};
        tbl[4]  = '{5,  pk(13, 10, 7, 4),   '0,             3'b100};
        tbl[5]  = '{6,  pk(14, 11, 8, 0),   pk(0, 1, 0, 0), 3'b100};
        tbl[6]  = '{7,  pk(15, 12, 0, 0),   '0,             3'b100};
        tbl[7]  = '{8,  pk(16, 0, 0, 0),    pk(1, 0, 0, 0), 3'b100};
        tbl[8]  = '{9,  '0,                 '0,             3'b100};
        tbl[9]  = '{12, '0,                 '0,             3'b100};
        tbl[10] = '{13, '0,                 '0,             3'b010};
        tbl[11] = '{14, '0,                 '0,             3'b000};

        rst = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_idx = '0; ld_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();
        check("reset_l", l_out, '0);
        check("reset_u", u_out, '0);
        check("reset_ctl", {{(N*W-4){1'b0}}, busy, done, acc_clr, ld_ready}, pk(0, 0, 0, 1));

        for (int i = 0; i < N; i++) load(1'b0, i, pk(4*i + 4, 4*i + 3, 4*i + 2, 4*i + 1));
        for (int j = 0; j < N; j++) load(1'b1, j, pk(j == 3, j == 2, j == 1, j == 0));

        run_table("run1", 0, 0, 1'b0);
        run_table("rerun", 0, 0, 1'b0);
        run_table("pulse", 4, 0, 1'b0);
        run_table("busyld", 0, 6, 1'b0);
        run_table("olddata", 0, 0, 1'b0);
        run_table("ldstart", 0, 0, 1'b1);
        run_table("after", 0, 0, 1'b0);

        // Reset during the first DRAIN cycle, then a run with the cleared operands.
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("midrst_l", l_out, '0);
        check("midrst_u", u_out, '0);
        check("midrst_ctl", {{(N*W-3){1'b0}}, busy, done, acc_clr}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = 1'b0;
            if (c >= 2 && c <= 8) check($sformatf("zero_lu_c%0d", c), l_out | u_out, '0);
            if (c == 13) begin
                check("zero_done", {{(N*W-2){1'b0}}, busy, done}, pk(0, 0, 0, 1));
                check_array("zero_array", 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
